// File: rtl/beat_display_sequencer.sv
// Frame-synchronous beat/BPM scheduler for the VGA overlay: beat_pulse and bpm_estimate
// only move on a vsync falling edge (or a watchdog tick when vsync stalls).
module beat_display_sequencer #(
   parameter int HOLD_FRAMES    = 4,
   parameter int DECAY_FRAMES   = 2,
   parameter int MIN_BPM        = 40,
   parameter int MAX_BPM        = 240,
   parameter int BPM_RESET      = 120,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       beat_valid_i,
   input  logic [1:0] beat_level_i,
   output logic       beat_ready_o,
   input  logic       bpm_valid_i,
   input  logic [8:0] bpm_in_i,
   input  logic       vga_vs_i,
   output logic [1:0] beat_pulse_o,
   output logic [8:0] bpm_estimate_o,
   output logic       busy_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_DECAY = 2'd2;

   localparam int MAX_FRAMES = (HOLD_FRAMES > DECAY_FRAMES) ? HOLD_FRAMES : DECAY_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
   localparam int WD_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [8:0]       MIN_V    = 9'(MIN_BPM);
   localparam logic [8:0]       MAX_V    = 9'(MAX_BPM);
   localparam logic [8:0]       RESET_V  = 9'(BPM_RESET);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_FRAMES - 1);
   localparam logic [CNT_W-1:0] DECAY_LD = CNT_W'(DECAY_FRAMES - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

   logic             vs_q;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             wd_tick, frame_tick;
   logic             pend_v_q, pend_v_d;
   logic [1:0]       pend_level_q, pend_level_d;
   logic [8:0]       shadow_q, shadow_d, bpm_clamped;
   logic [8:0]       bpm_q, bpm_d;
   logic [1:0]       pulse_q, pulse_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   assign wd_tick    = (wd_q == WD_LAST);
   assign frame_tick = (vs_q & ~vga_vs_i) | wd_tick;
   assign accept     = beat_valid_i & ~pend_v_q;

   always_comb begin
      wd_d = frame_tick ? '0 : wd_q + 1'b1;

      if (bpm_in_i < MIN_V)      bpm_clamped = MIN_V;
      else if (bpm_in_i > MAX_V) bpm_clamped = MAX_V;
      else                       bpm_clamped = bpm_in_i;
      shadow_d = bpm_valid_i ? bpm_clamped : shadow_q;

      // accept only happens with the buffer empty, so clear and load never collide
      pend_v_d     = pend_v_q;
      pend_level_d = pend_level_q;
      if (frame_tick) pend_v_d = 1'b0;
      if (accept && beat_level_i != 2'd0) begin
         pend_v_d     = 1'b1;
         pend_level_d = beat_level_i;
      end
   end

   always_comb begin
      state_d = state_q;
      pulse_d = pulse_q;
      cnt_d   = cnt_q;
      bpm_d   = bpm_q;
      if (frame_tick) begin
         bpm_d = shadow_q;
         if (pend_v_q) begin
            state_d = ST_HOLD;
            pulse_d = pend_level_q;
            cnt_d   = HOLD_LD;
         end else if (state_q == ST_HOLD || state_q == ST_DECAY) begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               pulse_d = pulse_q - 2'd1;
               if (pulse_q == 2'd1) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DECAY;
                  cnt_d   = DECAY_LD;
               end
            end
         end else begin
            state_d = ST_IDLE;
            pulse_d = 2'd0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         vs_q         <= 1'b1;
         wd_q         <= '0;
         pend_v_q     <= 1'b0;
         pend_level_q <= 2'd0;
         shadow_q     <= RESET_V;
         bpm_q        <= RESET_V;
         pulse_q      <= 2'd0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
      end else begin
         vs_q         <= vga_vs_i;
         wd_q         <= wd_d;
         pend_v_q     <= pend_v_d;
         pend_level_q <= pend_level_d;
         shadow_q     <= shadow_d;
         bpm_q        <= bpm_d;
         pulse_q      <= pulse_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
      end
   end

   assign beat_ready_o   = ~pend_v_q;
   assign beat_pulse_o   = pulse_q;
   assign bpm_estimate_o = bpm_q;
   assign busy_o         = (state_q != ST_IDLE) | pend_v_q;

endmodule

// File: tb/tb_beat_display_sequencer.sv
// Scoreboard bench for beat_display_sequencer: directed frames push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_beat_display_sequencer;

   localparam int TO = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic       beat_valid;
   logic [1:0] beat_level;
   logic       beat_ready;
   logic       bpm_valid;
   logic [8:0] bpm_in;
   logic       vga_vs;
   logic [1:0] beat_pulse;
   logic [8:0] bpm_estimate;
   logic       busy;

   typedef struct {
      string name;
      int    sel;
      int    exp;
   } chk_t;

   chk_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   int t2_exp[9] = '{3, 3, 3, 3, 2, 2, 1, 1, 0};
   int t4_exp[7] = '{2, 2, 2, 2, 1, 1, 0};
   int t5_exp[5] = '{3, 3, 3, 3, 2};

   beat_display_sequencer #(
      .HOLD_FRAMES(4), .DECAY_FRAMES(2), .MIN_BPM(40), .MAX_BPM(240),
      .BPM_RESET(120), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .beat_valid_i(beat_valid), .beat_level_i(beat_level), .beat_ready_o(beat_ready),
      .bpm_valid_i(bpm_valid), .bpm_in_i(bpm_in), .vga_vs_i(vga_vs),
      .beat_pulse_o(beat_pulse), .bpm_estimate_o(bpm_estimate), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // sel: 0 pulse, 1 bpm, 2 busy, 3 ready
   always @(negedge clk) begin
      chk_t c;
      int   act;
      while (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         case (c.sel)
            0:       act = int'(beat_pulse);
            1:       act = int'(bpm_estimate);
            2:       act = int'(busy);
            default: act = int'(beat_ready);
         endcase
         total++;
         if (act != c.exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
         end else begin
            $display("ok   %s = %0d", c.name, act);
         end
      end
   end

   task automatic chk(input string nm, input int sel, input int v);
      chk_t c;
      c.name = nm;
      c.sel  = sel;
      c.exp  = v;
      exp_q.push_back(c);
   endtask

   task automatic chk_all(input string nm, input int p, input int b, input int bz);
      chk({nm, ".pulse"}, 0, p);
      chk({nm, ".bpm"},   1, b);
      chk({nm, ".busy"},  2, bz);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one vsync falling edge; returns just after the edge on which the DUT updates
   task automatic frame();
      @(posedge clk); #1;
      vga_vs = 1'b0;
      @(posedge clk); #1;
      vga_vs = 1'b1;
   endtask

   task automatic beat(input logic [1:0] lvl);
      beat_valid = 1'b1;
      beat_level = lvl;
      @(posedge clk); #1;
      beat_valid = 1'b0;
   endtask

   task automatic bpm(input logic [8:0] v);
      bpm_valid = 1'b1;
      bpm_in    = v;
      @(posedge clk); #1;
      bpm_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; beat_valid = 1'b0; beat_level = 2'd0;
      bpm_valid = 1'b0; bpm_in = 9'd0; vga_vs = 1'b1;
      cyc(3);
      chk_all("reset", 0, 120, 0);
      chk("reset.ready", 3, 1);
      reset = 1'b0;
      cyc(1);

      // T1: idle frames
      repeat (3) begin
         frame();
         chk_all("t1", 0, 120, 0);
      end

      // T2: level 3 hold-then-decay
      beat(2'd3);
      chk("t2.ready_pend", 3, 0);
      chk_all("t2.pend", 0, 120, 1);
      for (int i = 0; i < 9; i++) begin
         frame();
         chk_all($sformatf("t2.f%0d", i), t2_exp[i], 120, (i < 8) ? 1 : 0);
         if (i == 0) chk("t2.ready_after", 3, 1);
      end

      // T3: clamp and frame-synchronous BPM
      bpm(9'd300);
      cyc(1);
      bpm(9'd20);
      chk("t3.midframe", 1, 120);
      frame();
      chk("t3.low_clamp", 1, 40);
      bpm(9'd300);
      frame();
      chk("t3.high_clamp", 1, 240);
      bpm(9'd150);
      cyc(2);
      chk("t3.hold", 1, 240);
      frame();
      chk("t3.pass", 1, 150);

      // T4: second beat refused while pending
      beat(2'd2);
      chk("t4.ready0", 3, 0);
      beat(2'd1);
      chk("t4.ready_still0", 3, 0);
      chk("t4.no_tick", 0, 0);
      for (int i = 0; i < 7; i++) begin
         frame();
         chk($sformatf("t4.f%0d", i), 0, t4_exp[i]);
         if (i == 0) chk("t4.ready_after", 3, 1);
      end
      chk("t4.busy_end", 2, 0);

      // T5: beat and bpm accepted in a DECAY tick cycle land on the following tick
      beat(2'd3);
      for (int i = 0; i < 5; i++) begin
         frame();
         chk($sformatf("t5.f%0d", i), 0, t5_exp[i]);
      end
      @(posedge clk); #1;
      vga_vs = 1'b0; beat_valid = 1'b1; beat_level = 2'd1; bpm_valid = 1'b1; bpm_in = 9'd100;
      @(posedge clk); #1;
      vga_vs = 1'b1; beat_valid = 1'b0; bpm_valid = 1'b0;
      chk_all("t5.tick_cycle", 2, 150, 1);
      chk("t5.tick_ready", 3, 0);
      frame();
      chk_all("t5.retrig", 1, 100, 1);
      chk("t5.retrig_ready", 3, 1);
      repeat (3) begin
         frame();
         chk("t5.hold1", 0, 1);
      end
      frame();
      chk_all("t5.end", 0, 100, 0);

      // T6: vsync stalled, watchdog drives frames; then async reset mid-HOLD
      beat(2'd2);
      cyc(TO - 2);
      chk_all("t6.before_wd", 0, 100, 1);
      cyc(1);
      chk("t6.wd1", 0, 2);
      cyc(TO);
      chk("t6.wd2", 0, 2);
      cyc(TO);
      chk("t6.wd3", 0, 2);
      cyc(2);
      #2 reset = 1'b1;
      chk_all("t6.async_reset", 0, 120, 0);
      chk("t6.reset_ready", 3, 1);
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      cyc(2);
      chk("t6.after_reset", 0, 0);

      cyc(2);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
